mem_port_arbiter: RTL and testbench

- Shares the single 256x8 RAM port between two requesters: the instruction-fetch side (the IR load path) and the data side (MAR/MDR load/store path).
- Grants one requester at a time and drives the RAM handshake: MOV, R_W, DT and address.
- Waits for MOC, returns read data and a one-cycle acknowledge to the granted requester.
- Sits between the control unit/datapath registers and ram256x8.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ==========================================================================
// mem_port_arbiter: fetch/data arbiter driving the shared 256x8 RAM port.
// Optional MEM_TIMEOUT_EN aborts a WAIT after TIMEOUT cycles with err. Rev 1.0
// ==========================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_dt,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_dt,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_moc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   grant_data;
    logic   last_grant_data;
    logic   pick_data;
    logic   start;
    logic   timeout_hit;

    // A lingering MOC from the previous access blocks any new grant.
    assign start     = (f_req | d_req) & ~mem_moc;
    assign pick_data = d_req & (~f_req | ~last_grant_data);

`ifdef MEM_TIMEOUT_EN
    logic [3:0] tcnt;
    logic       err_q;

    assign timeout_hit = (state == S_WAIT) & ~mem_moc & (tcnt == 4'(TIMEOUT - 1));
    assign err         = err_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tcnt  <= 4'd0;
            err_q <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                tcnt <= 4'd0;
            else if (state == S_WAIT && !mem_moc)
                tcnt <= tcnt + 4'd1;
            if (timeout_hit)
                err_q <= 1'b1;
            else if (state == S_DONE)
                err_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mem_mov  = 1'b0;
        busy     = 1'b1;
        f_ack    = 1'b0;
        d_ack    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                mem_mov  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                mem_mov = 1'b1;
                if (mem_moc || timeout_hit)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                f_ack    = ~grant_data;
                d_ack    = grant_data;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            grant_data      <= 1'b0;
            last_grant_data <= 1'b1;
            mem_rw          <= 1'b1;
            mem_addr        <= '0;
            mem_dt          <= 2'b10;
            mem_wdata       <= '0;
            f_rdata         <= '0;
            d_rdata         <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                grant_data      <= pick_data;
                last_grant_data <= pick_data;
                if (pick_data) begin
                    mem_addr  <= d_addr;
                    mem_rw    <= ~d_we;
                    mem_dt    <= d_dt;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_addr <= f_addr;
                    mem_rw   <= 1'b1;
                    mem_dt   <= 2'b10;
                end
            end
            // Stores leave d_rdata untouched; a timed-out access returns zero.
            if (state == S_WAIT && mem_moc) begin
                if (!grant_data)
                    f_rdata <= mem_rdata;
                else if (mem_rw)
                    d_rdata <= mem_rdata;
            end else if (timeout_hit) begin
                if (!grant_data)
                    f_rdata <= '0;
                else
                    d_rdata <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ==========================================================================
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        f_req = 1'b0;
    logic [7:0]  f_addr = '0;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_dt = 2'b10;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        busy;
    logic        mem_mov;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_dt;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_moc = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .clr(clr),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_dt(d_dt), .d_ack(d_ack), .d_rdata(d_rdata),
        .err(err), .busy(busy),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_dt(mem_dt),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at the falling edge of the first mem_mov cycle.
    task automatic wait_mov();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_mov;
        end
        check("mov_seen", 64'(seen), 64'd1);
    endtask

    // Raises MOC dly cycles after mem_mov went high; ends at the falling edge of DONE.
    task automatic complete(input int dly, input logic [31:0] rd, input bit stick);
        repeat (dly) @(posedge clk);
        #1;
        mem_moc   = 1'b1;
        mem_rdata = rd;
        tick();
        if (!stick) mem_moc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_mov", 64'(mem_mov), 64'd0);
        check("rst_rw", 64'(mem_rw), 64'd1);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_dt", 64'(mem_dt), 64'd2);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_flags", {60'd0, f_ack, d_ack, err, busy}, 64'd0);
        check("rst_rdata", {f_rdata, d_rdata}, 64'd0);
        tick();
        clr = 1'b1;

        // Single fetch, address changed after grant must not matter
        tick();
        f_req  = 1'b1;
        f_addr = 8'h10;
        wait_mov();
        check("f_rw", 64'(mem_rw), 64'd1);
        check("f_dt", 64'(mem_dt), 64'd2);
        check("f_addr", 64'(mem_addr), 64'h10);
        check("f_busy", 64'(busy), 64'd1);
        f_addr = 8'h55;
        complete(2, 32'hE3A01005, 1'b0);
        check("f_ack", {62'd0, f_ack, d_ack}, 64'd2);
        check("f_rdata", 64'(f_rdata), 64'hE3A01005);
        check("f_done_mov", 64'(mem_mov), 64'd0);
        check("f_addr_hold", 64'(mem_addr), 64'h10);
        tick();
        f_req = 1'b0;
        @(negedge clk);
        check("f_ack_once", 64'(f_ack), 64'd0);
        check("f_idle", {63'd0, busy}, 64'd0);

        // MOC stuck high: pending data request must wait in IDLE
        tick();
        f_req  = 1'b1;
        f_addr = 8'h11;
        wait_mov();
        complete(1, 32'h0BADF00D, 1'b1);
        check("stk_f_ack", 64'(f_ack), 64'd1);
        tick();
        f_req  = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 8'h22;
        d_dt   = 2'b01;
        repeat (3) tick();
        @(negedge clk);
        check("stk_no_mov", {62'd0, mem_mov, busy}, 64'd0);
        tick();
        mem_moc = 1'b0;
        wait_mov();
        check("stk_addr", 64'(mem_addr), 64'h22);
        check("stk_dt_rw", {62'd0, mem_dt}, 64'd1);
        check("stk_rw", 64'(mem_rw), 64'd1);
        complete(1, 32'h5A5A1234, 1'b0);
        check("stk_d_ack", {62'd0, f_ack, d_ack}, 64'd1);
        check("stk_d_rdata", 64'(d_rdata), 64'h5A5A1234);
        tick();
        d_req = 1'b0;

        // Data store: d_rdata keeps the previous load
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 8'h40;
        d_dt    = 2'b00;
        d_wdata = 32'h000000AB;
        wait_mov();
        check("st_rw", 64'(mem_rw), 64'd0);
        check("st_dt", 64'(mem_dt), 64'd0);
        check("st_addr", 64'(mem_addr), 64'h40);
        check("st_wdata", 64'(mem_wdata), 64'hAB);
        d_wdata = 32'hFFFFFFFF;
        complete(3, 32'hDEADBEEF, 1'b0);
        check("st_ack", 64'(d_ack), 64'd1);
        check("st_rdata_keep", 64'(d_rdata), 64'h5A5A1234);
        check("st_wdata_hold", 64'(mem_wdata), 64'hAB);
        tick();
        d_req = 1'b0;
        d_we  = 1'b0;

        // Never-answering RAM
        tick();
        d_req  = 1'b1;
        d_addr = 8'h60;
        d_dt   = 2'b10;
        wait_mov();
        @(posedge clk);
`ifdef MEM_TIMEOUT_EN
        begin
            int cyc = 0;
            for (int i = 1; i <= 40 && cyc == 0; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (d_ack) cyc = i;
            end
            check("to_cycles", 64'(cyc), 64'd15);
            check("to_err", 64'(err), 64'd1);
            check("to_rdata", 64'(d_rdata), 64'd0);
            tick();
            d_req = 1'b0;
            @(negedge clk);
            check("to_err_clr", {62'd0, err, d_ack}, 64'd0);
        end
`else
        begin
            bit acked = 1'b0;
            for (int i = 1; i <= 100; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (d_ack) acked = 1'b1;
            end
            check("nto_no_ack", 64'(acked), 64'd0);
            check("nto_waiting", {61'd0, busy, mem_mov, err}, 64'd6);
            tick();
            clr   = 1'b0;
            d_req = 1'b0;
            tick();
            clr = 1'b1;
        end
`endif

        // Reset in the middle of a fetch WAIT, then contention
        tick();
        f_req  = 1'b1;
        f_addr = 8'h30;
        wait_mov();
        @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check("rm_mov", 64'(mem_mov), 64'd0);
        check("rm_state", {61'd0, busy, f_ack, d_ack}, 64'd0);
        check("rm_addr", 64'(mem_addr), 64'd0);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 8'h44;
        d_dt   = 2'b10;
        @(negedge clk);
        check("rm_no_ack", {62'd0, f_ack, d_ack}, 64'd0);
        tick();
        clr = 1'b1;
        wait_mov();
        check("c1_addr", 64'(mem_addr), 64'h30);
        complete(1, 32'h11111111, 1'b0);
        check("c1_ack", {62'd0, f_ack, d_ack}, 64'd2);
        check("c1_rdata", 64'(f_rdata), 64'h11111111);
        tick();
        wait_mov();
        check("c2_addr", 64'(mem_addr), 64'h44);
        complete(2, 32'h22222222, 1'b0);
        check("c2_ack", {62'd0, f_ack, d_ack}, 64'd1);
        check("c2_rdata", 64'(d_rdata), 64'h22222222);
        check("c2_mov", 64'(mem_mov), 64'd0);
        tick();
        wait_mov();
        check("c3_addr", 64'(mem_addr), 64'h30);
        complete(1, 32'h33333333, 1'b0);
        check("c3_ack", {62'd0, f_ack, d_ack}, 64'd2);
        check("c3_rdata", 64'(f_rdata), 64'h33333333);
        tick();
        f_req = 1'b0;
        d_req = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
